conv_mem_responder: RTL and testbench

- Memory-side responder for the image convolution engine. Serves the image read port (iaddr/idata) and the layer-memory read/write port (csel/crd/cwr).
- Sequences the host image load and the ready/busy handshake with the engine.
- After the engine finishes, streams any selected layer bank back to the host over a valid/ready drain port.
- Sits between the host/DMA stream and the convolution engine as the sole owner of all image and layer storage.

---
 rtl/conv_mem_pkg.sv | 38 +++
 rtl/conv_bank_ram.sv | 25 ++
 rtl/conv_mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_conv_mem_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mem_pkg.sv
// Widths, bank map and FSM encoding shared by the convolution memory responder.
package conv_mem_pkg;
  localparam int DW        = 20;
  localparam int AW        = 12;
  localparam int IMG_DEPTH = 4096;
  localparam int L0_DEPTH  = 4096;
  localparam int L1_DEPTH  = 1024;
  localparam int L2_DEPTH  = 2048;

  localparam logic [2:0] CSEL_NONE = 3'd0;
  localparam logic [2:0] CSEL_L0K0 = 3'd1;
  localparam logic [2:0] CSEL_L0K1 = 3'd2;
  localparam logic [2:0] CSEL_L1K0 = 3'd3;
  localparam logic [2:0] CSEL_L1K1 = 3'd4;
  localparam logic [2:0] CSEL_L2   = 3'd5;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_READY,
    ST_RUN,
    ST_DONE,
    ST_DRAIN
  } state_t;

  // Zero depth marks a select that maps to no bank.
  function automatic int bank_depth(input logic [2:0] csel);
    case (csel)
      CSEL_L0K0, CSEL_L0K1: return L0_DEPTH;
      CSEL_L1K0, CSEL_L1K1: return L1_DEPTH;
      CSEL_L2:              return L2_DEPTH;
      default:              return 0;
    endcase
  endfunction

  function automatic logic csel_valid(input logic [2:0] csel);
    return bank_depth(csel) != 0;
  endfunction
endpackage

// File: rtl/conv_bank_ram.sv
// Storage bank: one synchronous write port, two combinational read ports.
// A read of the address being written returns the old word until the edge.
module conv_bank_ram #(
  parameter int DEPTH = 4096,
  parameter int DW    = 20,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/conv_mem_responder.sv
// Owns image and layer storage; sequences host load, engine handshake and bank drain.
// Reads are combinational; the drain holds address/data while dr_ready is low.
module conv_mem_responder
  import conv_mem_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          restart,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  input  logic          dr_start,
  input  logic [2:0]    dr_sel,
  output logic          dr_valid,
  input  logic          dr_ready,
  output logic [AW-1:0] dr_addr,
  output logic [DW-1:0] dr_data,
  output logic          done,
  output logic          err
);
  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [AW-1:0] dr_addr_nx;
  logic [2:0]    dr_sel_q, dr_sel_nx;
  logic          busy_d, busy_dd;

  logic ld_fire, dr_fire, dr_sel_ok;
  logic wr_sel_ok, wr_oob, wr_ok, err_set;

  logic [DW-1:0] img_rd_unused;
  logic [DW-1:0] bank_crd [1:5];
  logic [DW-1:0] bank_drd [1:5];

  assign ld_ready = (state == ST_LOAD);
  assign ready    = (state == ST_READY);
  assign dr_valid = (state == ST_DRAIN);
  assign done     = (state == ST_DONE) || (state == ST_DRAIN);

  assign ld_fire   = ld_valid && ld_ready;
  assign dr_fire   = dr_valid && dr_ready;
  assign dr_sel_ok = csel_valid(dr_sel);

  // Out-of-range writes are dropped rather than aliased by address truncation.
  assign wr_sel_ok = csel_valid(csel);
  assign wr_oob    = wr_sel_ok && (int'(caddr_wr) >= bank_depth(csel));
  assign wr_ok     = cwr && wr_sel_ok && !wr_oob;

  assign err_set = (cwr && !wr_sel_ok)
                || (cwr && wr_oob)
                || (cwr && crd)
                || (cwr && (state != ST_RUN))
                || (ld_valid && (state != ST_LOAD))
                || ((state == ST_DONE) && dr_start && !dr_sel_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_LOAD;
      cnt      <= '0;
      dr_addr  <= '0;
      dr_sel_q <= CSEL_NONE;
      busy_d   <= 1'b0;
      busy_dd  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      dr_addr  <= dr_addr_nx;
      dr_sel_q <= dr_sel_nx;
      busy_d   <= busy;
      busy_dd  <= busy_d;
      err      <= err || err_set;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    dr_addr_nx = dr_addr;
    dr_sel_nx  = dr_sel_q;
    case (state)
      ST_LOAD: begin
        if (ld_fire) begin
          cnt_nx = cnt + 1'b1;
          if (cnt == AW'(IMG_DEPTH - 1)) begin
            cnt_nx   = '0;
            state_nx = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (busy) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (busy_dd && !busy_d) state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (restart) begin
          state_nx = ST_LOAD;
          cnt_nx   = '0;
        end else if (dr_start && dr_sel_ok) begin
          state_nx   = ST_DRAIN;
          dr_sel_nx  = dr_sel;
          dr_addr_nx = '0;
        end
      end
      ST_DRAIN: begin
        if (dr_fire) begin
          if (dr_addr == AW'(bank_depth(dr_sel_q) - 1)) begin
            state_nx   = ST_DONE;
            dr_addr_nx = '0;
          end else begin
            dr_addr_nx = dr_addr + 1'b1;
          end
        end
      end
      default: state_nx = ST_LOAD;
    endcase
  end

  conv_bank_ram #(.DEPTH(IMG_DEPTH), .DW(DW)) u_img (
    .clk     (clk),
    .we      (ld_fire),
    .waddr   (cnt),
    .wdata   (ld_data),
    .raddr_a (iaddr),
    .rdata_a (idata),
    .raddr_b (iaddr),
    .rdata_b (img_rd_unused)
  );

  // Bank k serves csel==k; its address ports use only the low bits it needs.
  for (genvar k = 1; k <= 5; k++) begin : g_bank
    localparam int D  = bank_depth(3'(k));
    localparam int BA = $clog2(D);
    conv_bank_ram #(.DEPTH(D), .DW(DW)) u_ram (
      .clk     (clk),
      .we      (wr_ok && (csel == 3'(k))),
      .waddr   (caddr_wr[BA-1:0]),
      .wdata   (cdata_wr),
      .raddr_a (caddr_rd[BA-1:0]),
      .rdata_a (bank_crd[k]),
      .raddr_b (dr_addr[BA-1:0]),
      .rdata_b (bank_drd[k])
    );
  end

  always_comb begin
    cdata_rd = '0;
    case (csel)
      CSEL_L0K0: cdata_rd = bank_crd[1];
      CSEL_L0K1: cdata_rd = bank_crd[2];
      CSEL_L1K0: cdata_rd = bank_crd[3];
      CSEL_L1K1: cdata_rd = bank_crd[4];
      CSEL_L2:   cdata_rd = bank_crd[5];
      default:   cdata_rd = '0;
    endcase
  end

  always_comb begin
    dr_data = '0;
    if (dr_valid) begin
      case (dr_sel_q)
        CSEL_L0K0: dr_data = bank_drd[1];
        CSEL_L0K1: dr_data = bank_drd[2];
        CSEL_L1K0: dr_data = bank_drd[3];
        CSEL_L1K1: dr_data = bank_drd[4];
        CSEL_L2:   dr_data = bank_drd[5];
        default:   dr_data = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_mem_responder.sv
// Bench for conv_mem_responder: read-vector table, handshake sequences and drain scoreboard.
module tb_conv_mem_responder;
  import conv_mem_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_valid, ld_ready, restart, ready, busy;
  logic [DW-1:0] ld_data, idata, cdata_wr, cdata_rd, dr_data;
  logic [AW-1:0] iaddr, caddr_wr, caddr_rd, dr_addr;
  logic          cwr, crd, dr_start, dr_valid, dr_ready, done, err;
  logic [2:0]    csel, dr_sel;

  always #5 clk = ~clk;

  conv_mem_responder dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .restart(restart), .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .dr_start(dr_start), .dr_sel(dr_sel), .dr_valid(dr_valid), .dr_ready(dr_ready),
    .dr_addr(dr_addr), .dr_data(dr_data), .done(done), .err(err)
  );

  typedef struct {
    bit            is_img;
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } rd_vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_ent_t;

  int            checks = 0;
  int            errors = 0;
  rd_vec_t       vecs [14];
  sb_ent_t       sb [$];
  sb_ent_t       e;
  logic [DW-1:0] l2_model [L2_DEPTH];
  logic [AW-1:0] held_addr;
  bit            held;
  int            hold_cnt;
  int            cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cwr = 1'b1; csel = s; caddr_wr = a; cdata_wr = d;
    tick();
    cwr = 1'b0;
  endtask

  task automatic load_image(input logic [DW-1:0] xorv);
    for (int i = 0; i < IMG_DEPTH; i++) begin
      ld_valid = 1'b1;
      ld_data  = DW'(i) ^ xorv;
      if (i == IMG_DEPTH - 1) begin
        #1;
        chk("ld_ready_last_word", ld_ready, 1);
      end
      tick();
    end
    ld_valid = 1'b0;
    chk("ld_ready_after_load", ld_ready, 0);
    chk("ready_after_load", ready, 1);
  endtask

  initial begin
    reset = 1'b1;
    ld_valid = 0; ld_data = '0; restart = 0; busy = 0; iaddr = '0;
    cwr = 0; caddr_wr = '0; cdata_wr = '0; crd = 0; caddr_rd = '0; csel = '0;
    dr_start = 0; dr_sel = '0; dr_ready = 0;

    vecs[0]  = '{1'b1, 3'd0, 12'h041, 20'h00041};
    vecs[1]  = '{1'b1, 3'd0, 12'h000, 20'h00000};
    vecs[2]  = '{1'b1, 3'd0, 12'hFFF, 20'h00FFF};
    vecs[3]  = '{1'b1, 3'd0, 12'h800, 20'h00800};
    vecs[4]  = '{1'b0, 3'd3, 12'h005, 20'h0ABCD};
    vecs[5]  = '{1'b0, 3'd4, 12'h005, 20'h0F0F0};
    vecs[6]  = '{1'b0, 3'd1, 12'hFFF, 20'h13579};
    vecs[7]  = '{1'b0, 3'd2, 12'hFFF, 20'h2468A};
    vecs[8]  = '{1'b0, 3'd5, 12'hFFF, 20'h5A5A5};
    vecs[9]  = '{1'b0, 3'd5, 12'h7FF, 20'h5A5A5};
    vecs[10] = '{1'b0, 3'd0, 12'h005, 20'h00000};
    vecs[11] = '{1'b0, 3'd6, 12'hFFF, 20'h00000};
    vecs[12] = '{1'b0, 3'd7, 12'h005, 20'h00000};
    vecs[13] = '{1'b0, 3'd3, 12'h405, 20'h0ABCD};

    #12;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_dr_valid", dr_valid, 0);
    chk("rst_dr_addr", dr_addr, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    tick();

    load_image(20'h00000);

    hold_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ready) hold_cnt++;
    end
    chk("ready_hold_100", hold_cnt, 100);
    busy = 1'b1;
    tick();
    chk("ready_drop_on_busy", ready, 0);

    wr(3'd3, 12'h005, 20'h0ABCD);
    crd = 1'b1; csel = 3'd3; caddr_rd = 12'h005;
    #1;
    chk("layer_rd_after_wr", cdata_rd, 20'h0ABCD);
    chk("err_clean_run", err, 0);
    crd = 1'b0;
    wr(3'd4, 12'h005, 20'h0F0F0);
    wr(3'd1, 12'hFFF, 20'h13579);
    wr(3'd2, 12'hFFF, 20'h2468A);
    wr(3'd3, 12'h000, 20'h33333);
    for (int i = 0; i < L2_DEPTH; i++) begin
      l2_model[i] = DW'(i * 37 + 4660);
      wr(3'd5, AW'(i), l2_model[i]);
    end
    wr(3'd5, 12'h7FF, 20'h5A5A5);
    l2_model[12'h7FF] = 20'h5A5A5;

    // read-during-write: old word in the write cycle, new word after the edge
    wr(3'd3, 12'h006, 20'h11111);
    cwr = 1'b1; csel = 3'd3; caddr_wr = 12'h006; cdata_wr = 20'h22222; caddr_rd = 12'h006;
    #1;
    chk("rdw_old_data", cdata_rd, 20'h11111);
    tick();
    cwr = 1'b0;
    #1;
    chk("rdw_new_data", cdata_rd, 20'h22222);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_img) iaddr = vecs[i].addr;
      else begin csel = vecs[i].sel; caddr_rd = vecs[i].addr; end
      #1;
      chk($sformatf("rd_vec%0d", i), vecs[i].is_img ? idata : cdata_rd, vecs[i].exp);
      tick();
    end
    chk("err_before_oob", err, 0);

    wr(3'd3, 12'h400, 20'h12345);
    chk("err_oob_write", err, 1);
    csel = 3'd3; caddr_rd = 12'h000;
    #1;
    chk("oob_write_discarded", cdata_rd, 20'h33333);

    busy = 1'b0;
    tick();
    chk("done_one_cycle_after_drop", done, 0);
    tick();
    chk("done_two_cycles_after_drop", done, 1);

    dr_sel = 3'd5; dr_start = 1'b1;
    for (int i = 0; i < L2_DEPTH; i++) sb.push_back('{AW'(i), l2_model[i]});
    tick();
    dr_start = 1'b0;
    chk("drain_start_valid", dr_valid, 1);
    chk("drain_start_addr", dr_addr, 0);
    cyc = 0; held = 0;
    while (sb.size() > 0 && cyc < 10000) begin
      dr_ready = cyc[0];
      #1;
      if (held) begin
        chk("drain_hold_addr", dr_addr, held_addr);
        held = 0;
      end
      if (dr_valid && dr_ready) begin
        e = sb.pop_front();
        chk("drain_addr", dr_addr, e.addr);
        chk("drain_data", dr_data, e.data);
      end else if (dr_valid) begin
        held = 1; held_addr = dr_addr;
      end
      tick();
      cyc++;
    end
    dr_ready = 1'b0;
    chk("drain_all_words", sb.size(), 0);
    chk("drain_end_valid", dr_valid, 0);
    chk("drain_end_addr", dr_addr, 0);
    chk("drain_end_done", done, 1);
    chk("err_sticky", err, 1);

    dr_ready = 1'b1; dr_sel = 3'd5; dr_start = 1'b1;
    tick();
    dr_start = 1'b0;
    cyc = 0;
    while (dr_addr != 12'h123 && cyc < 5000) begin
      tick();
      cyc++;
    end
    chk("drain_reached_123", dr_addr, 12'h123);
    dr_ready = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("arst_dr_valid", dr_valid, 0);
    chk("arst_ld_ready", ld_ready, 1);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_dr_addr", dr_addr, 0);
    reset = 1'b0;
    tick();

    load_image(20'hFFFFF);
    iaddr = 12'h041; csel = 3'd3; caddr_rd = 12'h005;
    #1;
    chk("reload_idata", idata, 20'hFFFBE);
    chk("bank_kept_l1", cdata_rd, 20'h0ABCD);
    csel = 3'd5; caddr_rd = 12'h123;
    #1;
    chk("bank_kept_l2", cdata_rd, l2_model[12'h123]);
    chk("err_after_reload", err, 0);

    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    chk("pulse_done_early", done, 0);
    tick();
    chk("pulse_done", done, 1);

    dr_start = 1'b1; dr_sel = 3'd0;
    tick();
    dr_start = 1'b0;
    chk("bad_dr_sel_err", err, 1);
    chk("bad_dr_sel_ignored", dr_valid, 0);

    dr_start = 1'b1; dr_sel = 3'd5; restart = 1'b1;
    tick();
    dr_start = 1'b0; restart = 1'b0;
    chk("restart_wins_ld_ready", ld_ready, 1);
    chk("restart_wins_dr_valid", dr_valid, 0);
    chk("restart_wins_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
